// File: rtl/pipeline_types.sv
// Shared types for the LED frame scheduler: FSM state encoding, the 24-bit GRB pixel,
// and a helper that sizes a counter to hold a given maximum value.
package pipeline_types;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_BIT_HI,
        ST_BIT_LO,
        ST_LATCH
    } state_t;

    typedef logic [23:0] pixel_t;

    localparam int PIXEL_BITS = 24;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/led_frame_scheduler_if.sv
// Pixel fetch handshake between the frame scheduler (master) and the pixel source (slave).
interface led_frame_scheduler_if #(
    parameter int IDX_W = 1
);
    import pipeline_types::*;

    logic             o_pix_req;
    logic [IDX_W-1:0] o_pix_idx;
    logic             i_pix_valid;
    pixel_t           i_pix_data;

    modport master (
        output o_pix_req,
        output o_pix_idx,
        input  i_pix_valid,
        input  i_pix_data
    );

    modport slave (
        input  o_pix_req,
        input  o_pix_idx,
        output i_pix_valid,
        output i_pix_data
    );

endinterface

// File: rtl/led_bit_encoder.sv
// Times one LED bit: counts the bit period from a start strobe and flags the end of the
// high phase (length depends on the bit value) and the end of the whole bit.
module led_bit_encoder
    import pipeline_types::*;
#(
    parameter int T0H_CYCLES = 20,
    parameter int T1H_CYCLES = 40,
    parameter int BIT_CYCLES = 62
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_bit,
    output logic o_hi_end,
    output logic o_bit_done
);

    localparam int CNT_W = cnt_width(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HI0_LAST = CNT_W'(T0H_CYCLES - 1);
    localparam logic [CNT_W-1:0] HI1_LAST = CNT_W'(T1H_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_bit;
    logic             r_active;
    logic [CNT_W-1:0] w_hi_last;

    assign w_hi_last  = r_bit ? HI1_LAST : HI0_LAST;
    assign o_hi_end   = r_active && (r_cnt == w_hi_last);
    assign o_bit_done = r_active && (r_cnt == BIT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_bit    <= 1'b0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_cnt    <= '0;
            r_bit    <= i_bit;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt == BIT_LAST) begin
                r_cnt    <= '0;
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_frame_scheduler.sv
// Frame scheduler for a single-wire LED chain: fetches NUM_LEDS GRB pixels, serialises them
// MSB first with pulse-width bit coding, then holds the line low for the latch interval.
module led_frame_scheduler
    import pipeline_types::*;
#(
    parameter int NUM_LEDS      = 8,
    parameter int T0H_CYCLES    = 20,
    parameter int T1H_CYCLES    = 40,
    parameter int BIT_CYCLES    = 62,
    parameter int LATCH_CYCLES  = 2500,
    parameter int FETCH_TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    output logic o_busy,
    output logic o_serial,
    output logic o_done,
    output logic o_underrun,
    led_frame_scheduler_if.master pix
);

    localparam int IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int BITCNT_W = cnt_width(PIXEL_BITS - 1);
    localparam int CYC_MAX  = ((LATCH_CYCLES > FETCH_TIMEOUT) ? LATCH_CYCLES : FETCH_TIMEOUT) - 1;
    localparam int CYC_W    = cnt_width(CYC_MAX);

    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_LEDS - 1);
    localparam logic [BITCNT_W-1:0] LAST_BIT   = BITCNT_W'(PIXEL_BITS - 1);
    localparam logic [CYC_W-1:0]    FETCH_LAST = CYC_W'(FETCH_TIMEOUT - 1);
    localparam logic [CYC_W-1:0]    LATCH_LAST = CYC_W'(LATCH_CYCLES - 1);

    state_t              r_state;
    pixel_t              r_shift;
    logic [BITCNT_W-1:0] r_bit_cnt;
    logic [CYC_W-1:0]    r_cyc;
    logic [IDX_W-1:0]    r_idx;
    logic                r_busy;
    logic                r_pix_req;
    logic                r_serial;
    logic                r_done;
    logic                r_underrun;

    logic w_enc_start;
    logic w_enc_bit;
    logic w_hi_end;
    logic w_bit_done;
    logic w_last_bit;

    // The encoder restarts on pixel acceptance or at the end of every bit but the 24th.
    assign w_last_bit  = (r_bit_cnt == LAST_BIT);
    assign w_enc_start = ((r_state == ST_FETCH) && pix.i_pix_valid) ||
                         ((r_state == ST_BIT_LO) && w_bit_done && !w_last_bit);
    assign w_enc_bit   = (r_state == ST_FETCH) ? pix.i_pix_data[PIXEL_BITS-1]
                                               : r_shift[PIXEL_BITS-2];

    led_bit_encoder #(
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES),
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_encoder (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (w_enc_start),
        .i_bit      (w_enc_bit),
        .o_hi_end   (w_hi_end),
        .o_bit_done (w_bit_done)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: the shift register is reset too, so an aborted frame leaves no stale pixel behind.
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_cyc      <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_pix_req  <= 1'b0;
            r_serial   <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (i_start && !r_done) begin
                        r_state    <= ST_FETCH;
                        r_busy     <= 1'b1;
                        r_pix_req  <= 1'b1;
                        r_idx      <= '0;
                        r_cyc      <= '0;
                        r_underrun <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (pix.i_pix_valid) begin
                        r_shift   <= pix.i_pix_data;
                        r_bit_cnt <= '0;
                        r_pix_req <= 1'b0;
                        r_serial  <= 1'b1;
                        r_state   <= ST_BIT_HI;
                    end else if (r_cyc == FETCH_LAST) begin
                        r_pix_req  <= 1'b0;
                        r_underrun <= 1'b1;
                        r_cyc      <= '0;
                        r_state    <= ST_LATCH;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                ST_BIT_HI: begin
                    if (w_hi_end) begin
                        r_serial <= 1'b0;
                        r_state  <= ST_BIT_LO;
                    end
                end
                ST_BIT_LO: begin
                    if (w_bit_done) begin
                        r_shift <= {r_shift[PIXEL_BITS-2:0], 1'b0};
                        if (!w_last_bit) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_serial  <= 1'b1;
                            r_state   <= ST_BIT_HI;
                        end else if (r_idx == LAST_IDX) begin
                            r_cyc   <= '0;
                            r_state <= ST_LATCH;
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_pix_req <= 1'b1;
                            r_cyc     <= '0;
                            r_state   <= ST_FETCH;
                        end
                    end
                end
                ST_LATCH: begin
                    if (r_cyc == LATCH_LAST) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_pix_req <= 1'b0;
                    r_serial  <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_serial      = r_serial;
    assign o_done        = r_done;
    assign o_underrun    = r_underrun;
    assign pix.o_pix_req = r_pix_req;
    assign pix.o_pix_idx = r_idx;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Self-checking bench: a per-cycle expected waveform is built from the frame rules
// (fetch wait, pulse-width bits, latch, done) and compared against the scheduler outputs.
module tb_led_frame_scheduler;

    localparam int NUM_LEDS = 2;
    localparam int T0H      = 2;
    localparam int T1H      = 4;
    localparam int BITC     = 6;
    localparam int LATCH    = 10;
    localparam int TIMEOUT  = 8;
    localparam int IDX_W    = 1;

    typedef struct packed {
        logic             serial;
        logic             busy;
        logic             req;
        logic [IDX_W-1:0] idx;
        logic             done;
        logic             underrun;
    } obs_t;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic busy, serial, done, underrun;

    led_frame_scheduler_if #(.IDX_W(IDX_W)) pix ();

    led_frame_scheduler #(
        .NUM_LEDS      (NUM_LEDS),
        .T0H_CYCLES    (T0H),
        .T1H_CYCLES    (T1H),
        .BIT_CYCLES    (BITC),
        .LATCH_CYCLES  (LATCH),
        .FETCH_TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .o_busy     (busy),
        .o_serial   (serial),
        .o_done     (done),
        .o_underrun (underrun),
        .pix        (pix)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [23:0] pix_mem [NUM_LEDS];
    int          delay   [NUM_LEDS];
    bit          tie_valid = 1'b1;
    int          fetch_cnt = 0;
    obs_t        exp_q [$];
    logic        ur_model  = 1'b0;
    int          done_at;

    // Pixel source: answers the delay-th FETCH cycle (or at once when valid is tied high);
    // outside FETCH it drives junk data and random valid, which the scheduler must ignore.
    always @(negedge clk) begin
        if (pix.o_pix_req) begin
            pix.i_pix_data  = pix_mem[pix.o_pix_idx];
            pix.i_pix_valid = tie_valid || (fetch_cnt == delay[pix.o_pix_idx] - 1);
            fetch_cnt++;
        end else begin
            pix.i_pix_data  = 24'($urandom);
            pix.i_pix_valid = tie_valid || 1'($urandom);
            fetch_cnt       = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entry i of exp_q is the output state right after the i-th edge following the start edge.
    task automatic plan_frame();
        obs_t e;
        bit   aborted;
        aborted = 1'b0;
        exp_q.delete();
        e = '0;
        for (int p = 0; p < NUM_LEDS && !aborted; p++) begin
            int fc;
            bit to;
            to = !tie_valid && (delay[p] > TIMEOUT);
            fc = tie_valid ? 1 : (to ? TIMEOUT : delay[p]);
            e.serial = 1'b0; e.busy = 1'b1; e.req = 1'b1; e.idx = IDX_W'(p);
            e.done = 1'b0; e.underrun = 1'b0;
            repeat (fc) exp_q.push_back(e);
            if (to) begin
                aborted = 1'b1;
            end else begin
                e.req = 1'b0;
                for (int b = 23; b >= 0; b--) begin
                    int th;
                    th = pix_mem[p][b] ? T1H : T0H;
                    e.serial = 1'b1;
                    repeat (th) exp_q.push_back(e);
                    e.serial = 1'b0;
                    repeat (BITC - th) exp_q.push_back(e);
                end
            end
        end
        e.serial = 1'b0; e.req = 1'b0; e.busy = 1'b1; e.underrun = aborted;
        repeat (LATCH) exp_q.push_back(e);
        e.busy = 1'b0; e.done = 1'b1;
        exp_q.push_back(e);
        e.done = 1'b0;
        exp_q.push_back(e);
        ur_model = aborted;
    endtask

    task automatic run_frame(input bit stray);
        plan_frame();
        done_at = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(posedge clk);
            #1;
            start = 1'b0;
            if (done === 1'b1 && done_at < 0) done_at = i;
            check($sformatf("serial@%0d", i), 32'(serial), 32'(exp_q[i].serial));
            check($sformatf("busy@%0d", i), 32'(busy), 32'(exp_q[i].busy));
            check($sformatf("req@%0d", i), 32'(pix.o_pix_req), 32'(exp_q[i].req));
            check($sformatf("done@%0d", i), 32'(done), 32'(exp_q[i].done));
            check($sformatf("underrun@%0d", i), 32'(underrun), 32'(exp_q[i].underrun));
            if (exp_q[i].req) check($sformatf("idx@%0d", i), 32'(pix.o_pix_idx), 32'(exp_q[i].idx));
            if (stray && i < exp_q.size() - 1)
                start = exp_q[i].done ? 1'b1 : 1'($urandom_range(0, 9) == 0);
        end
        start = 1'b0;
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check("idle_busy", 32'(busy), 32'(0));
            check("idle_done", 32'(done), 32'(0));
            check("idle_serial", 32'(serial), 32'(0));
            check("idle_req", 32'(pix.o_pix_req), 32'(0));
            check("idle_underrun", 32'(underrun), 32'(ur_model));
        end
    endtask

    task automatic randomize_pixels();
        for (int p = 0; p < NUM_LEDS; p++) pix_mem[p] = 24'($urandom);
    endtask

    initial begin
        for (int p = 0; p < NUM_LEDS; p++) begin
            pix_mem[p] = '0;
            delay[p]   = 1;
        end

        #1 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_serial", 32'(serial), 32'(0));
        check("rst_req", 32'(pix.o_pix_req), 32'(0));
        check("rst_idx", 32'(pix.o_pix_idx), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_underrun", 32'(underrun), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_check(3);

        // Valid tied high: 1+144+1+144 fetch/bit cycles and 10 latch cycles put done 300 edges
        // after the edge that samples start (the 301st cycle counting the start cycle).
        tie_valid  = 1'b1;
        pix_mem[0] = 24'hFF0000;
        pix_mem[1] = 24'h00000F;
        run_frame(1'b0);
        check("done_latency", 32'(done_at), 32'(300));
        idle_check(3);

        tie_valid = 1'b0;
        delay[0]  = 1;
        delay[1]  = 5;
        run_frame(1'b0);
        idle_check(2);

        delay[1] = 99;
        run_frame(1'b0);
        idle_check(5);

        randomize_pixels();
        for (int p = 0; p < NUM_LEDS; p++) delay[p] = $urandom_range(1, TIMEOUT);
        run_frame(1'b1);
        idle_check(2);

        // Reset during the first high phase of pixel 0 must clear outputs without a clock edge.
        tie_valid = 1'b1;
        randomize_pixels();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_serial", 32'(serial), 32'(1));
        check("pre_rst_busy", 32'(busy), 32'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_serial", 32'(serial), 32'(0));
        check("async_rst_busy", 32'(busy), 32'(0));
        check("async_rst_req", 32'(pix.o_pix_req), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        ur_model = 1'b0;
        idle_check(20);
        run_frame(1'b0);
        idle_check(2);

        repeat (6) begin
            tie_valid = 1'($urandom_range(0, 1));
            randomize_pixels();
            for (int p = 0; p < NUM_LEDS; p++) delay[p] = $urandom_range(1, TIMEOUT + 2);
            run_frame(1'($urandom_range(0, 1)));
            idle_check($urandom_range(1, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
